// File: rtl/roundrobin_pkg.sv
// -----------------------------------------------------------------------------
// roundrobin_pkg
// Shared types and helpers for the weighted round-robin arbiter.
//   rr_state_e : arbiter FSM state (IDLE, GRANT)
//   idx_width  : width of a requester index, max(1, $clog2(n))
// -----------------------------------------------------------------------------
package roundrobin_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } rr_state_e;

    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating priority picker. Finds the first eligible requester
// (req & mask) searching upward from ptr_i and wrapping modulo N.
// Ports:
//   req_i    [N-1:0]  request vector
//   mask_i   [N-1:0]  eligibility mask (0 excludes that requester)
//   ptr_i    [IW-1:0] index with highest priority
//   found_o           at least one eligible requester
//   winner_o [IW-1:0] index of the chosen requester (0 when none)
// -----------------------------------------------------------------------------
module rr_priority_pick
    import roundrobin_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              req_i,
    input  logic [N-1:0]              mask_i,
    input  logic [idx_width(N)-1:0]   ptr_i,
    output logic                      found_o,
    output logic [idx_width(N)-1:0]   winner_o
);

    localparam int IW = idx_width(N);

    logic [N-1:0] eligible;

    assign eligible = req_i & mask_i;

    // Walk offsets from farthest to nearest so the nearest eligible index
    // (the one with the highest rotated priority) is the last to be written.
    always_comb begin
        int idx;
        idx      = 0;
        found_o  = 1'b0;
        winner_o = '0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = (int'(ptr_i) + off) % N;
            if (eligible[idx]) begin
                found_o  = 1'b1;
                winner_o = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/roundrobin_weighted_slice.sv
// -----------------------------------------------------------------------------
// roundrobin_weighted_slice
// Round-robin arbiter for N requesters where each requester owns the bus for
// up to its own slice length (quantum) before priority rotates. The owner
// releases early by dropping its request; hand-off is back-to-back.
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   REQ         [N-1:0]          level-sensitive requests
//   SLICE_LEN   [N*SLICE_W-1:0]  slice length per requester (0 acts as 1)
//   GNT         [N-1:0]          registered one-hot grant, zero when idle
//   GNT_VALID                    any grant active
//   GNT_ID      [IW-1:0]         current owner, holds last owner when idle
//   SLICE_LEFT  [SLICE_W-1:0]    cycles left in slice including this one
// -----------------------------------------------------------------------------
module roundrobin_weighted_slice
    import roundrobin_pkg::*;
#(
    parameter int N       = 4,
    parameter int SLICE_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N-1:0]              REQ,
    input  logic [N*SLICE_W-1:0]      SLICE_LEN,
    output logic [N-1:0]              GNT,
    output logic                      GNT_VALID,
    output logic [idx_width(N)-1:0]   GNT_ID,
    output logic [SLICE_W-1:0]        SLICE_LEFT
);

    localparam int IW = idx_width(N);

    rr_state_e          state_q, state_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [IW-1:0]      id_q, id_d;
    logic [SLICE_W-1:0] left_q, left_d;
    logic [IW-1:0]      ptr_q, ptr_d;

    logic [N-1:0]       pick_mask;
    logic               pick_found;
    logic [IW-1:0]      pick_winner;
    logic [SLICE_W-1:0] win_len;
    logic               arb;

    rr_priority_pick #(
        .N (N)
    ) u_pick (
        .req_i    (REQ),
        .mask_i   (pick_mask),
        .ptr_i    (ptr_q),
        .found_o  (pick_found),
        .winner_o (pick_winner)
    );

    assign win_len = SLICE_LEN[pick_winner*SLICE_W +: SLICE_W];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        left_d    = left_q;
        ptr_d     = ptr_q;
        pick_mask = '1;
        arb       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                arb = 1'b1;
            end
            ST_GRANT: begin
                if (!REQ[id_q]) begin
                    // Early release: the departing owner must not win again.
                    arb            = 1'b1;
                    pick_mask[id_q] = 1'b0;
                end else if (left_q == SLICE_W'(1)) begin
                    // Slice expired: ptr already sits at owner+1, so the owner
                    // is naturally searched last and a lone requester re-wins.
                    arb = 1'b1;
                end else begin
                    left_d = left_q - SLICE_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (arb) begin
            if (pick_found) begin
                state_d            = ST_GRANT;
                gnt_d              = '0;
                gnt_d[pick_winner] = 1'b1;
                id_d               = pick_winner;
                left_d             = (win_len == '0) ? SLICE_W'(1) : win_len;
                ptr_d              = (pick_winner == IW'(N - 1)) ? '0 : pick_winner + 1'b1;
            end else begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                left_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            left_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            left_q  <= left_d;
            ptr_q   <= ptr_d;
        end
    end

    assign GNT        = gnt_q;
    assign GNT_VALID  = |gnt_q;
    assign GNT_ID     = id_q;
    assign SLICE_LEFT = left_q;

endmodule

// File: tb/tb_roundrobin_weighted_slice.sv
// -----------------------------------------------------------------------------
// tb_roundrobin_weighted_slice
// Directed scenarios for the weighted round-robin arbiter. Each step drives REQ,
// pushes the grant/slice expected after the next edge, and compares on the
// following falling edge.
// -----------------------------------------------------------------------------
module tb_roundrobin_weighted_slice;

    localparam int N  = 4;
    localparam int SW = 4;
    localparam int IW = 2;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*SW-1:0]   slice_len;
    logic [N-1:0]      gnt;
    logic              gnt_valid;
    logic [IW-1:0]     gnt_id;
    logic [SW-1:0]     slice_left;

    int n_checks = 0;
    int n_errors = 0;

    logic [N+SW-1:0] exp_q[$];
    logic [IW-1:0]   last_id;

    roundrobin_weighted_slice #(
        .N       (N),
        .SLICE_W (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .REQ        (req),
        .SLICE_LEN  (slice_len),
        .GNT        (gnt),
        .GNT_VALID  (gnt_valid),
        .GNT_ID     (gnt_id),
        .SLICE_LEFT (slice_left)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_slices(input int s3, input int s2, input int s1, input int s0);
        slice_len = {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
    endtask

    // Reset from a falling-edge position, released on a later falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        req     = '0;
        last_id = '0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // driver + scoreboard: drive REQ, expect (eg, el) after the next edge
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] eg,
                        input logic [SW-1:0] el, input string tag);
        logic [N+SW-1:0] e;
        logic [N-1:0]    e_gnt;
        req = r;
        exp_q.push_back({eg, el});
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, " queue"}, 32'd0, 32'd1);
        end else begin
            e     = exp_q.pop_front();
            e_gnt = e[N+SW-1:SW];
            for (int i = 0; i < N; i++) begin
                if (e_gnt[i]) last_id = IW'(i);
            end
            check({tag, " gnt"},   32'(gnt),        32'(e_gnt));
            check({tag, " valid"}, 32'(gnt_valid),  32'(|e_gnt));
            check({tag, " id"},    32'(gnt_id),     32'(last_id));
            check({tag, " left"},  32'(slice_left), 32'(e[SW-1:0]));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        last_id = '0;
        set_slices(2, 2, 2, 2);

        // reset state while rst_n is low
        #3;
        check("rst gnt",   32'(gnt),        32'd0);
        check("rst valid", 32'(gnt_valid),  32'd0);
        check("rst id",    32'(gnt_id),     32'd0);
        check("rst left",  32'(slice_left), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // idle with no requests
        for (int i = 0; i < 10; i++) step(4'b0000, 4'b0000, 4'd0, "idle");

        // full-load rotation, all slices 2
        do_reset();
        set_slices(2, 2, 2, 2);
        step(4'b1111, 4'b0001, 4'd2, "rot0");
        step(4'b1111, 4'b0001, 4'd1, "rot1");
        step(4'b1111, 4'b0010, 4'd2, "rot2");
        step(4'b1111, 4'b0010, 4'd1, "rot3");
        step(4'b1111, 4'b0100, 4'd2, "rot4");
        step(4'b1111, 4'b0100, 4'd1, "rot5");
        step(4'b1111, 4'b1000, 4'd2, "rot6");
        step(4'b1111, 4'b1000, 4'd1, "rot7");
        step(4'b1111, 4'b0001, 4'd2, "rot8");
        step(4'b0000, 4'b0000, 4'd0, "rot_idle");

        // weighted slices: req3..0 = 1,3,2,4
        do_reset();
        set_slices(1, 3, 2, 4);
        step(4'b1111, 4'b0001, 4'd4, "wt0");
        step(4'b1111, 4'b0001, 4'd3, "wt1");
        step(4'b1111, 4'b0001, 4'd2, "wt2");
        step(4'b1111, 4'b0001, 4'd1, "wt3");
        step(4'b1111, 4'b0010, 4'd2, "wt4");
        step(4'b1111, 4'b0010, 4'd1, "wt5");
        step(4'b1111, 4'b0100, 4'd3, "wt6");
        step(4'b1111, 4'b0100, 4'd2, "wt7");
        step(4'b1111, 4'b0100, 4'd1, "wt8");
        step(4'b1111, 4'b1000, 4'd1, "wt9");
        step(4'b1111, 4'b0001, 4'd4, "wt10");

        // early release, then a lone requester re-granted without a gap
        do_reset();
        set_slices(4, 2, 4, 2);
        step(4'b1010, 4'b0010, 4'd4, "er0");
        step(4'b1000, 4'b1000, 4'd4, "er1");
        step(4'b1000, 4'b1000, 4'd3, "er2");
        step(4'b0000, 4'b0000, 4'd0, "er_idle");
        step(4'b0100, 4'b0100, 4'd2, "lone0");
        step(4'b0100, 4'b0100, 4'd1, "lone1");
        step(4'b0100, 4'b0100, 4'd2, "lone2");
        step(4'b0100, 4'b0100, 4'd1, "lone3");
        step(4'b0000, 4'b0000, 4'd0, "lone_idle");

        // zero-length slice acts as 1; mid-slice SLICE_LEN change is ignored
        do_reset();
        set_slices(2, 2, 3, 0);
        step(4'b0011, 4'b0001, 4'd1, "zs0");
        step(4'b0011, 4'b0010, 4'd3, "zs1");
        set_slices(2, 2, 1, 0);
        step(4'b0011, 4'b0010, 4'd2, "zs2");
        step(4'b0011, 4'b0010, 4'd1, "zs3");
        step(4'b0011, 4'b0001, 4'd1, "zs4");
        step(4'b0011, 4'b0010, 4'd1, "zs5");
        step(4'b0011, 4'b0001, 4'd1, "zs6");

        // asynchronous reset between edges clears the grant at once
        do_reset();
        set_slices(2, 2, 2, 2);
        step(4'b0100, 4'b0100, 4'd2, "mr0");
        #2;
        rst_n = 1'b0;
        #1;
        check("mr async gnt",   32'(gnt),        32'd0);
        check("mr async valid", 32'(gnt_valid),  32'd0);
        check("mr async id",    32'(gnt_id),     32'd0);
        check("mr async left",  32'(slice_left), 32'd0);
        last_id = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, 4'b0001, 4'd2, "mr1");
        step(4'b1111, 4'b0001, 4'd1, "mr2");
        step(4'b1111, 4'b0010, 4'd2, "mr3");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
